// File: rtl/noise_gate.sv
// ---------------------------------------------------------------------------
// noise_gate
//   Sample-rate noise gate. It sits between the echo stage and the DAC and
//   mutes low-level hiss between notes. The gain is not switched hard. It
//   ramps linearly through CLOSED / ATTACK / OPEN / HOLD / RELEASE, so the
//   gate opens and closes without audible clicks. Each rising clk edge
//   carries one new sample.
//
// Parameters
//   RESOLUTION    sample width, signed two's complement
//   THRESHOLD     gate opens when |data_in| >= THRESHOLD
//   HOLD          samples spent in HOLD before RELEASE (>= 1)
//   ATTACK_STEP   gain increment per sample while ramping up   (1..256)
//   RELEASE_STEP  gain decrement per sample while ramping down (1..256)
//
// Ports
//   clk        in   1           sample clock, rising edge
//   rst        in   1           synchronous active-high reset
//   enable     in   1           1 = gate active, 0 = registered bypass
//   data_in    in   RESOLUTION  signed input sample
//   data_out   out  RESOLUTION  signed output sample, registered
//   gain       out  9           current gain, unsigned Q1.8 (256 = unity)
//   gate_open  out  1           1 while in ATTACK, OPEN or HOLD (registered)
// ---------------------------------------------------------------------------
module noise_gate #(
    parameter int RESOLUTION   = 24,
    parameter int THRESHOLD    = 4096,
    parameter int HOLD         = 1024,
    parameter int ATTACK_STEP  = 16,
    parameter int RELEASE_STEP = 1
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         enable,
    input  logic signed [RESOLUTION-1:0] data_in,
    output logic signed [RESOLUTION-1:0] data_out,
    output logic        [8:0]            gain,
    output logic                         gate_open
);

    // A HOLD of 1 still needs a one-bit counter.
    localparam int HOLD_W = (HOLD > 1) ? $clog2(HOLD) : 1;
    localparam int PROD_W = RESOLUTION + 10;

    localparam logic [HOLD_W-1:0]     HOLD_LOAD    = HOLD_W'(HOLD - 1);
    localparam logic [HOLD_W-1:0]     HOLD_ZERO    = HOLD_W'(0);
    localparam logic [HOLD_W-1:0]     HOLD_ONE     = HOLD_W'(1);
    localparam logic [8:0]            GAIN_UNITY   = 9'd256;
    localparam logic [8:0]            GAIN_ZERO    = 9'd0;
    localparam logic [9:0]            ATTACK_INC   = 10'(ATTACK_STEP);
    localparam logic [8:0]            RELEASE_DEC  = 9'(RELEASE_STEP);
    localparam logic [8:0]            ATTACK_FIRST = 9'(ATTACK_STEP);
    localparam logic [RESOLUTION-1:0] THRESH_C     = RESOLUTION'(THRESHOLD);
    localparam logic [RESOLUTION-1:0] ONE_C        = RESOLUTION'(1);
    localparam logic [RESOLUTION-1:0] ZERO_C       = RESOLUTION'(0);
    localparam logic [RESOLUTION-1:0] MOST_NEG_C   = {1'b1, {(RESOLUTION-1){1'b0}}};
    localparam logic [RESOLUTION-1:0] MAX_POS_C    = {1'b0, {(RESOLUTION-1){1'b1}}};

    typedef enum logic [2:0] {
        ST_CLOSED  = 3'd0,
        ST_ATTACK  = 3'd1,
        ST_OPEN    = 3'd2,
        ST_HOLD    = 3'd3,
        ST_RELEASE = 3'd4
    } state_t;

    // Absolute value. The most-negative code has no positive twin, so it
    // saturates to the largest positive value instead of wrapping to itself.
    function automatic logic [RESOLUTION-1:0] magnitude(input logic [RESOLUTION-1:0] x);
        logic [RESOLUTION-1:0] m;
        if (x == MOST_NEG_C) begin
            m = MAX_POS_C;
        end else if (x[RESOLUTION-1] == 1'b1) begin
            m = ~x + ONE_C;
        end else begin
            m = x;
        end
        return m;
    endfunction

    // Ramp gain up by one attack step, clamped at unity.
    function automatic logic [8:0] gain_up(input logic [8:0] g);
        logic [9:0] sum;
        logic [8:0] r;
        sum = {1'b0, g} + ATTACK_INC;
        if (sum >= 10'd256) begin
            r = GAIN_UNITY;
        end else begin
            r = sum[8:0];
        end
        return r;
    endfunction

    // Ramp gain down by one release step, clamped at zero.
    function automatic logic [8:0] gain_down(input logic [8:0] g);
        logic [8:0] r;
        if (g <= RELEASE_DEC) begin
            r = GAIN_ZERO;
        end else begin
            r = g - RELEASE_DEC;
        end
        return r;
    endfunction

    // Signed sample times unsigned Q1.8 gain, floored by the arithmetic
    // shift. Both operands are widened to the full product width first so
    // that the multiply is signed and the true product always fits.
    function automatic logic [RESOLUTION-1:0] scale_sample(
        input logic [RESOLUTION-1:0] x,
        input logic [8:0]            g
    );
        logic signed [PROD_W-1:0] x_ext;
        logic signed [PROD_W-1:0] g_ext;
        logic signed [PROD_W-1:0] prod;
        x_ext = {{10{x[RESOLUTION-1]}}, x};
        g_ext = {{(PROD_W-9){1'b0}}, g};
        prod  = x_ext * g_ext;
        return RESOLUTION'(prod >>> 4'd8);
    endfunction

    state_t                  state_r;
    state_t                  state_next_s;
    logic [8:0]              gain_r;
    logic [8:0]              gain_next_s;
    logic [8:0]              gain_up_s;
    logic [8:0]              gain_down_s;
    logic [HOLD_W-1:0]       hold_cnt_r;
    logic [HOLD_W-1:0]       hold_next_s;
    logic [RESOLUTION-1:0]   data_out_r;
    logic [RESOLUTION-1:0]   data_next_s;
    logic                    gate_open_r;
    logic                    gate_open_next_s;
    logic                    above_s;

    assign above_s   = (magnitude(data_in) >= THRESH_C);
    assign gain_up_s   = gain_up(gain_r);
    assign gain_down_s = gain_down(gain_r);

    // State register: FSM state, gain, hold counter and the registered outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r     <= ST_CLOSED;
            gain_r      <= GAIN_ZERO;
            hold_cnt_r  <= HOLD_ZERO;
            data_out_r  <= ZERO_C;
            gate_open_r <= 1'b0;
        end else begin
            state_r     <= state_next_s;
            gain_r      <= gain_next_s;
            hold_cnt_r  <= hold_next_s;
            data_out_r  <= data_next_s;
            gate_open_r <= gate_open_next_s;
        end
    end

    // Next-state logic: the gain ramps and hold countdown.
    always_comb begin
        state_next_s = state_r;
        gain_next_s  = gain_r;
        hold_next_s  = hold_cnt_r;
        if (!enable) begin
            // Bypass parks the gate fully open so that re-enabling does not click.
            state_next_s = ST_OPEN;
            gain_next_s  = GAIN_UNITY;
            hold_next_s  = HOLD_ZERO;
        end else begin
            case (state_r)
                ST_CLOSED: begin
                    if (above_s) begin
                        state_next_s = ST_ATTACK;
                        gain_next_s  = ATTACK_FIRST;
                    end else begin
                        state_next_s = ST_CLOSED;
                        gain_next_s  = GAIN_ZERO;
                    end
                end
                ST_ATTACK: begin
                    // The attack ramp runs to completion whatever the level.
                    gain_next_s = gain_up_s;
                    if (gain_up_s == GAIN_UNITY) begin
                        state_next_s = ST_OPEN;
                    end else begin
                        state_next_s = ST_ATTACK;
                    end
                end
                ST_OPEN: begin
                    gain_next_s = GAIN_UNITY;
                    if (!above_s) begin
                        state_next_s = ST_HOLD;
                        hold_next_s  = HOLD_LOAD;
                    end else begin
                        state_next_s = ST_OPEN;
                    end
                end
                ST_HOLD: begin
                    gain_next_s = GAIN_UNITY;
                    if (above_s) begin
                        state_next_s = ST_OPEN;
                    end else if (hold_cnt_r == HOLD_ZERO) begin
                        state_next_s = ST_RELEASE;
                    end else begin
                        state_next_s = ST_HOLD;
                        hold_next_s  = hold_cnt_r - HOLD_ONE;
                    end
                end
                ST_RELEASE: begin
                    if (above_s) begin
                        state_next_s = ST_ATTACK;
                        gain_next_s  = gain_up_s;
                    end else begin
                        gain_next_s = gain_down_s;
                        if (gain_down_s == GAIN_ZERO) begin
                            state_next_s = ST_CLOSED;
                        end else begin
                            state_next_s = ST_RELEASE;
                        end
                    end
                end
                default: begin
                    state_next_s = ST_CLOSED;
                    gain_next_s  = GAIN_ZERO;
                    hold_next_s  = HOLD_ZERO;
                end
            endcase
        end
    end

    // Output logic: gate_open is decoded from the next state, and the sample
    // is scaled by the gain held before this edge's update.
    always_comb begin
        gate_open_next_s = 1'b0;
        data_next_s      = ZERO_C;
        case (state_next_s)
            ST_ATTACK, ST_OPEN, ST_HOLD: gate_open_next_s = 1'b1;
            default:                     gate_open_next_s = 1'b0;
        endcase
        if (enable) begin
            data_next_s = scale_sample(data_in, gain_r);
        end else begin
            data_next_s = data_in;
        end
    end

    assign data_out  = data_out_r;
    assign gain      = gain_r;
    assign gate_open = gate_open_r;

endmodule

// File: tb/tb_noise_gate.sv
// ---------------------------------------------------------------------------
// tb_noise_gate
//   Directed bench for noise_gate with default parameters. Expected values
//   are worked out by hand from the gate's behaviour. One simple formula is
//   used for the release ramp.
// ---------------------------------------------------------------------------
module tb_noise_gate;

    logic        clk = 1'b0;
    logic        rst;
    logic        enable;
    logic [23:0] data_in;
    logic [23:0] data_out;
    logic [8:0]  gain;
    logic        gate_open;

    int checks = 0;
    int errors = 0;

    noise_gate dut (
        .clk       (clk),
        .rst       (rst),
        .enable    (enable),
        .data_in   (data_in),
        .data_out  (data_out),
        .gain      (gain),
        .gate_open (gate_open)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Apply one sample and sample the outputs 1 time unit after the edge.
    task automatic step(input logic en_v, input logic [23:0] d);
        enable  = en_v;
        data_in = d;
        @(posedge clk);
        #1;
    endtask

    initial begin
        // 1: reset dominates.
        rst = 1'b1;
        step(1'b1, 24'h7FFFFF);
        step(1'b1, 24'h7FFFFF);
        check("rst_data", 32'(data_out), 32'h0);
        check("rst_gain", 32'(gain), 32'd0);
        check("rst_gate", 32'(gate_open), 32'd0);

        // 2: bypass.
        rst = 1'b0;
        step(1'b0, 24'h123456);
        check("byp_data", 32'(data_out), 32'h123456);
        check("byp_gain", 32'(gain), 32'd256);
        check("byp_gate", 32'(gate_open), 32'd1);
        step(1'b0, 24'hFFFFFB);
        check("byp_neg", 32'(data_out), 32'hFFFFFB);

        // 3: quiet input keeps the gate closed, then the attack ramp starts.
        rst = 1'b1;
        step(1'b1, 24'd0);
        check("rst2_gain", 32'(gain), 32'd0);
        rst = 1'b0;
        for (int i = 0; i < 50; i++) begin
            step(1'b1, 24'd100);
            check("quiet_data", 32'(data_out), 32'h0);
            check("quiet_gate", 32'(gate_open), 32'd0);
        end
        for (int k = 1; k <= 17; k++) begin
            step(1'b1, 24'd8000);
            check("atk_data", 32'(data_out), 32'(24'(500 * (k - 1))));
            check("atk_gain", 32'(gain), 32'((16 * k > 256) ? 256 : 16 * k));
            check("atk_gate", 32'(gate_open), 32'd1);
        end

        // 4: hold for HOLD samples, then release 1/edge down to closed.
        for (int i = 1; i <= 1025; i++) begin
            step(1'b1, 24'd100);
            check("hold_data", 32'(data_out), 32'd100);
            check("hold_gain", 32'(gain), 32'd256);
            check("hold_gate", 32'(gate_open), 32'((i <= 1024) ? 1 : 0));
        end
        for (int j = 0; j < 256; j++) begin
            step(1'b1, 24'd100);
            check("rel_data", 32'(data_out), 32'((100 * (256 - j)) / 256));
            check("rel_gain", 32'(gain), 32'(255 - j));
            check("rel_gate", 32'(gate_open), 32'd0);
        end
        step(1'b1, 24'd100);
        check("closed_gain", 32'(gain), 32'd0);
        check("closed_data", 32'(data_out), 32'd0);

        // 5: retrigger in HOLD reloads the counter.
        for (int k = 0; k < 17; k++) step(1'b1, 24'd8000);
        check("open_gain", 32'(gain), 32'd256);
        step(1'b1, 24'd100);
        for (int k = 0; k < 500; k++) step(1'b1, 24'd100);
        check("hold500_gain", 32'(gain), 32'd256);
        check("hold500_gate", 32'(gate_open), 32'd1);
        step(1'b1, 24'd8000);
        check("retrig_data", 32'(data_out), 32'd8000);
        check("retrig_gain", 32'(gain), 32'd256);
        for (int i = 1; i <= 1025; i++) begin
            step(1'b1, 24'd100);
            check("reload_gain", 32'(gain), 32'd256);
            check("reload_gate", 32'(gate_open), 32'((i <= 1024) ? 1 : 0));
        end
        step(1'b1, 24'd100);
        check("reload_rel", 32'(gain), 32'd255);
        for (int k = 0; k < 155; k++) step(1'b1, 24'd100);
        check("rel100_gain", 32'(gain), 32'd100);
        // Retrigger during release resumes the attack from gain 100.
        step(1'b1, 24'd8000);
        check("rel_retrig_data", 32'(data_out), 32'd3125);
        check("rel_retrig_gain", 32'(gain), 32'd116);
        check("rel_retrig_gate", 32'(gate_open), 32'd1);

        // Reset mid-ramp aborts immediately.
        rst = 1'b1;
        step(1'b1, 24'd8000);
        check("midrst_gain", 32'(gain), 32'd0);
        check("midrst_gate", 32'(gate_open), 32'd0);
        check("midrst_data", 32'(data_out), 32'd0);
        rst = 1'b0;

        // 6: the most-negative sample counts as above threshold.
        step(1'b1, 24'h800000);
        check("mneg_open_gain", 32'(gain), 32'd16);
        check("mneg_open_gate", 32'(gate_open), 32'd1);
        step(1'b1, 24'h800000);
        check("mneg_g16_data", 32'(data_out), 32'hF80000);
        check("mneg_g16_gain", 32'(gain), 32'd32);
        for (int k = 0; k < 6; k++) step(1'b1, 24'd8000);
        check("g128", 32'(gain), 32'd128);
        step(1'b1, 24'hFFFFFF);
        check("floor_data", 32'(data_out), 32'hFFFFFF);
        check("floor_gain", 32'(gain), 32'd144);
        for (int k = 0; k < 7; k++) step(1'b1, 24'd8000);
        check("g256", 32'(gain), 32'd256);
        step(1'b1, 24'h800000);
        check("mneg_unity_data", 32'(data_out), 32'h800000);
        check("mneg_unity_gate", 32'(gate_open), 32'd1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
